// File: rtl/msg_scroll_ctrl.sv
// msg_scroll_ctrl
//   Stores a message of letter codes and scrolls an 8-character window across
//   an 8-digit 7-segment display. A writer fills the message buffer over a
//   valid/ready port. In RUN the window offset moves by one position every
//   SCROLL_DIV cycles. After the message, GAP blank positions are shown before
//   it repeats.
//
// Ports
//   clk        system clock
//   reset      asynchronous reset, active low
//   wr_valid   write beat valid
//   wr_ready   write beat accepted when wr_valid & wr_ready (IDLE only)
//   wr_code    letter code carried by the beat
//   wr_last    beat is the final character of the message
//   start      1-cycle pulse, begin scrolling (needs a loaded message)
//   stop       1-cycle pulse, stop scrolling and return to IDLE
//   hold       level, freezes the scroll timer
//   dir        0: offset +1 per step, 1: offset -1 per step
//   busy       high while scrolling
//   msg_len    latched message length, 0 when no message is loaded
//   frame_tick 1-cycle pulse whenever the window offset steps in RUN
//   win_codes  digit k code at [k*CODE_W +: CODE_W], digit 0 first
//
// Configuration
//   IDLE_BLINK_EN  when defined, a loaded message blinks in IDLE: the window
//                  alternates message / all blank every SCROLL_DIV cycles.
module msg_scroll_ctrl #(
  parameter int SCROLL_DIV = 50_000_000,
  parameter int MSG_DEPTH  = 16,
  parameter int GAP        = 2,
  parameter int CODE_W     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [CODE_W-1:0]     wr_code,
  input  logic                  wr_last,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  hold,
  input  logic                  dir,
  output logic                  busy,
  output logic [4:0]            msg_len,
  output logic                  frame_tick,
  output logic [8*CODE_W-1:0]   win_codes
);

  localparam int TW = $clog2(SCROLL_DIV);
  localparam int PW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam logic [TW-1:0]     TIMER_LAST = TW'(SCROLL_DIV - 1);
  localparam logic [PW-1:0]     PTR_LAST   = PW'(MSG_DEPTH - 1);
  localparam logic [CODE_W-1:0] BLANK      = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_next;

  logic [CODE_W-1:0]   msg_buf [MSG_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic                loaded;
  logic [4:0]          offset;
  logic [4:0]          offset_next;
  logic [TW-1:0]       timer;
  logic                blank_phase;
  logic                beat;
  logic                timer_done;
  logic [4:0]          cyc_len;
  logic [8*CODE_W-1:0] win_next;
  logic [4:0]          j;

  assign beat       = wr_valid && (state == IDLE);
  assign timer_done = (timer == TIMER_LAST);
  assign cyc_len    = msg_len + 5'(GAP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // A start that coincides with an accepted beat is dropped, because that
  // beat may be replacing the message that would be scrolled.
  always_comb begin
    state_next = state;
    wr_ready   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        if (start && loaded && !beat) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (stop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The offset always stays below cyc_len, so one compare is enough to wrap it.
  always_comb begin
    if (!dir) offset_next = (offset == cyc_len - 5'd1) ? 5'd0 : offset + 5'd1;
    else      offset_next = (offset == 5'd0) ? cyc_len - 5'd1 : offset - 5'd1;
  end

  // The buffer has no reset. Its contents are hidden while msg_len is 0.
  always_ff @(posedge clk) begin
    if (beat) msg_buf[wr_ptr] <= wr_code;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      msg_len    <= '0;
      loaded     <= 1'b0;
      offset     <= '0;
      timer      <= '0;
      frame_tick <= 1'b0;
`ifdef IDLE_BLINK_EN
      blank_phase <= 1'b0;
`endif
    end else begin
      frame_tick <= 1'b0;
      // A beat that fills the last slot ends the message even without wr_last.
      if (beat) begin
        if (wr_last || wr_ptr == PTR_LAST) begin
          msg_len <= 5'(wr_ptr) + 5'd1;
          wr_ptr  <= '0;
          loaded  <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + PW'(1);
          if (loaded) begin
            loaded  <= 1'b0;
            msg_len <= '0;
          end
        end
      end
      case (state)
        IDLE: begin
          if (state_next == RUN) begin
            timer  <= '0;
            offset <= '0;
`ifdef IDLE_BLINK_EN
            blank_phase <= 1'b0;
          end else if (!loaded || beat) begin
            timer       <= '0;
            blank_phase <= 1'b0;
          end else if (!hold) begin
            if (timer_done) begin
              timer       <= '0;
              blank_phase <= ~blank_phase;
            end else begin
              timer <= timer + TW'(1);
            end
`else
          end else begin
            timer <= '0;
`endif
          end
        end
        RUN: begin
          // stop takes priority over hold.
          if (stop) begin
            offset <= '0;
            timer  <= '0;
          end else if (!hold) begin
            if (timer_done) begin
              timer      <= '0;
              offset     <= offset_next;
              frame_tick <= 1'b1;
            end else begin
              timer <= timer + TW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifndef IDLE_BLINK_EN
  assign blank_phase = 1'b0;
`endif

  // The position index steps by one per digit. It wraps back to 0 at cyc_len,
  // so cycles shorter than 8 repeat within the window.
  always_comb begin
    win_next = '1;
    j        = offset;
    for (int k = 0; k < 8; k++) begin
      if (loaded && !blank_phase && j < msg_len)
        win_next[k*CODE_W +: CODE_W] = msg_buf[j[PW-1:0]];
      else
        win_next[k*CODE_W +: CODE_W] = BLANK;
      j = (j == cyc_len - 5'd1) ? 5'd0 : j + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) win_codes <= '1;
    else        win_codes <= win_next;
  end

endmodule

// File: tb/tb_msg_scroll_ctrl.sv
// tb_msg_scroll_ctrl
//   Directed bench for msg_scroll_ctrl with SCROLL_DIV=4, MSG_DEPTH=16, GAP=2,
//   CODE_W=5. Expected windows for each scroll step are queued before the run.
//   A monitor pops one entry per frame_tick and compares it with the window
//   one cycle later.
module tb_msg_scroll_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_valid = 1'b0;
  logic [4:0]  wr_code = '0;
  logic        wr_last = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        hold = 1'b0;
  logic        dir = 1'b0;
  logic        wr_ready;
  logic        busy;
  logic [4:0]  msg_len;
  logic        frame_tick;
  logic [39:0] win_codes;

  int          checks = 0;
  int          failures = 0;
  logic [39:0] exp_q[$];
  logic [4:0]  model_msg[16];
  int          model_len = 0;
  logic        tick_pending = 1'b0;

  localparam logic [39:0] ALL_BLANK = 40'hFF_FFFF_FFFF;
  localparam logic [4:0]  BL = 5'h1F;

  always #5 clk = ~clk;

  msg_scroll_ctrl #(
    .SCROLL_DIV(4),
    .MSG_DEPTH(16),
    .GAP(2),
    .CODE_W(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_code(wr_code),
    .wr_last(wr_last),
    .start(start),
    .stop(stop),
    .hold(hold),
    .dir(dir),
    .busy(busy),
    .msg_len(msg_len),
    .frame_tick(frame_tick),
    .win_codes(win_codes)
  );

  task automatic checkOutput(input string name, input logic [39:0] actual,
                             input logic [39:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] code, input logic last,
                               input logic st, input logic sp);
    wr_valid = v;
    wr_code  = code;
    wr_last  = last;
    start    = st;
    stop     = sp;
    cycle();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
  endtask

  function automatic logic [39:0] win8(input logic [4:0] d0, input logic [4:0] d1,
                                       input logic [4:0] d2, input logic [4:0] d3,
                                       input logic [4:0] d4, input logic [4:0] d5,
                                       input logic [4:0] d6, input logic [4:0] d7);
    return {d7, d6, d5, d4, d3, d2, d1, d0};
  endfunction

  function automatic logic [39:0] modelWin(input int off);
    logic [39:0] w;
    int l;
    int jj;
    l = model_len + 2;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      jj = (off + k) % l;
      w[k*5 +: 5] = (jj < model_len) ? model_msg[jj] : BL;
    end
    return w;
  endfunction

  task automatic waitTick(output int gap);
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      gap++;
      if (frame_tick) return;
    end
    checks++;
    failures++;
    $display("[TB] FAIL tick_timeout: got no frame_tick, expected one within 20 cycles");
  endtask

  // Monitor: the window settles one cycle after each frame_tick.
  always @(negedge clk) begin
    if (tick_pending) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_frame: got window %h, expected no frame", win_codes);
      end else begin
        checkOutput("frame_window", win_codes, exp_q.pop_front());
      end
    end
    tick_pending = reset && frame_tick;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int gap;
    int ticks;
    int extra;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 40'(busy), 40'd0);
    checkOutput("rst_msg_len", 40'(msg_len), 40'd0);
    checkOutput("rst_win", win_codes, ALL_BLANK);
    checkOutput("rst_wr_ready", 40'(wr_ready), 40'd1);
    checkOutput("rst_frame_tick", 40'(frame_tick), 40'd0);
    reset = 1'b1;
    cycle();

    // Ten-character message, codes 1..10.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 5'(i + 1), (i == 9), 1'b0, 1'b0);
      model_msg[i] = 5'(i + 1);
    end
    model_len = 10;
    cycle();
    checkOutput("len10", 40'(msg_len), 40'd10);
    checkOutput("win_load10", win_codes, win8(1, 2, 3, 4, 5, 6, 7, 8));

    // Forward scroll, L=12: 13 steps cover the wrap 11 -> 0 -> 1.
    dir = 1'b0;
    for (int s = 1; s <= 13; s++) exp_q.push_back(modelWin(s % 12));
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("run_busy", 40'(busy), 40'd1);
    checkOutput("run_wr_ready", 40'(wr_ready), 40'd0);
    extra = 0;
    for (int s = 1; s <= 13; s++) begin
      waitTick(gap);
      checkOutput($sformatf("gap_step%0d", s), 40'(gap), 40'(4 - extra));
      extra = 0;
      if (s == 2) begin
        cycle();
        extra = 1;
        checkOutput("step2_d6", 40'(win_codes[34:30]), 40'd9);
        checkOutput("step2_d7", 40'(win_codes[39:35]), 40'd10);
      end
      if (s == 11) begin
        cycle();
        extra = 1;
        checkOutput("step11_d0", 40'(win_codes[4:0]), 40'(BL));
        checkOutput("step11_d1", 40'(win_codes[9:5]), 40'd1);
        checkOutput("step11_d2", 40'(win_codes[14:10]), 40'd2);
      end
      if (s == 13) begin
        cycle();
        extra = 1;
        checkOutput("step13_d0", 40'(win_codes[4:0]), 40'd2);
      end
    end
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("stop_busy", 40'(busy), 40'd0);
    checkOutput("stop_len_kept", 40'(msg_len), 40'd10);
    checkOutput("stop_wr_ready", 40'(wr_ready), 40'd1);
    cycle();
    checkOutput("stop_win_off0", win_codes, win8(1, 2, 3, 4, 5, 6, 7, 8));

    // Three-character message 5,6,7 replaces the old one.
    applyStimulus(1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("newmsg_len0", 40'(msg_len), 40'd0);
    applyStimulus(1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    model_msg[0] = 5'd5;
    model_msg[1] = 5'd6;
    model_msg[2] = 5'd7;
    model_len = 3;
    cycle();
    checkOutput("len3", 40'(msg_len), 40'd3);
    checkOutput("win_len3", win_codes, win8(5, 6, 7, BL, BL, 5, 6, 7));

    // Reverse scroll with a hold in the middle.
    dir = 1'b1;
    exp_q.push_back(modelWin(4));
    exp_q.push_back(modelWin(3));
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    waitTick(gap);
    checkOutput("rev_gap1", 40'(gap), 40'd4);
    cycle();
    checkOutput("rev_win_off4", win_codes, win8(BL, 5, 6, 7, BL, BL, 5, 6));
    hold = 1'b1;
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (frame_tick) ticks++;
    end
    checkOutput("hold_no_tick", 40'(ticks), 40'd0);
    checkOutput("hold_win_frozen", win_codes, win8(BL, 5, 6, 7, BL, BL, 5, 6));
    hold = 1'b0;
    waitTick(gap);
    checkOutput("rev_gap_after_hold", 40'(gap), 40'd3);
    hold = 1'b1;
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("stop_beats_hold", 40'(busy), 40'd0);
    hold = 1'b0;
    cycle();
    checkOutput("stop_win_len3", win_codes, win8(5, 6, 7, BL, BL, 5, 6, 7));

    // Reset while scrolling.
    dir = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("rerun_busy", 40'(busy), 40'd1);
    cycle();
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrun_rst_busy", 40'(busy), 40'd0);
    checkOutput("midrun_rst_len", 40'(msg_len), 40'd0);
    checkOutput("midrun_rst_win", win_codes, ALL_BLANK);
    checkOutput("midrun_rst_wr_ready", 40'(wr_ready), 40'd1);
    reset = 1'b1;
    cycle();

    // Sixteen beats without wr_last. The last slot forces the end of the message.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 5'(i + 3), 1'b0, 1'b0, 1'b0);
      model_msg[i] = 5'(i + 3);
    end
    model_len = 16;
    cycle();
    checkOutput("len16_forced", 40'(msg_len), 40'd16);
    checkOutput("win_len16", win_codes, win8(3, 4, 5, 6, 7, 8, 9, 10));
`ifdef IDLE_BLINK_EN
    repeat (5) cycle();
    checkOutput("blink_blank", win_codes, ALL_BLANK);
    repeat (4) cycle();
    checkOutput("blink_msg", win_codes, win8(3, 4, 5, 6, 7, 8, 9, 10));
`endif

    // Start together with a beat: the beat wins and a new message begins.
    applyStimulus(1'b1, 5'd20, 1'b0, 1'b1, 1'b0);
    checkOutput("beat_start_busy", 40'(busy), 40'd0);
    checkOutput("beat_start_len0", 40'(msg_len), 40'd0);
    checkOutput("beat_start_wr_ready", 40'(wr_ready), 40'd1);
    cycle();
    checkOutput("beat_start_idle", 40'(busy), 40'd0);
    checkOutput("beat_start_win", win_codes, ALL_BLANK);

    cycle();
    checkOutput("frames_left", 40'(exp_q.size()), 40'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
